// File: rtl/divider_pipelined.sv
// Pipelined restoring divider: WIDTH/STAGES shift-subtract iterations per registered stage.
// Signed (DIV/REM) handling is built only when DIVIDER_SIGNED_EN is defined.
module divider_pipelined #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 8,
  parameter int unsigned TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  input  logic             i_signed,
  input  logic [TAG_W-1:0] i_tag,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic [TAG_W-1:0] o_tag
);

  localparam int unsigned ITER = WIDTH / STAGES;

  typedef struct packed {
    logic             valid;
`ifdef DIVIDER_SIGNED_EN
    logic             neg_q;
    logic             neg_r;
`endif
    logic             dz;
    logic [TAG_W-1:0] tag;
    logic [WIDTH-1:0] dvd;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] orig;
  } stage_t;

  stage_t st  [STAGES];
  stage_t nxt [STAGES];
  stage_t op;
  stage_t last;
  logic   adv;

  // ITER restoring iterations; the WIDTH+1 compare keeps the shifted-out carry
  function automatic stage_t step(input stage_t s);
    stage_t         n;
    logic [WIDTH:0] r_ext;
    n = s;
    for (int unsigned i = 0; i < ITER; i++) begin
      r_ext = {n.rem, n.dvd[WIDTH-1]};
      n.dvd = n.dvd << 1;
      n.quo = n.quo << 1;
      if (r_ext >= {1'b0, n.dvs}) begin
        r_ext    = r_ext - {1'b0, n.dvs};
        n.quo[0] = 1'b1;
      end
      n.rem = r_ext[WIDTH-1:0];
    end
    return n;
  endfunction

  assign last    = st[STAGES-1];
  assign o_valid = last.valid;
  assign adv     = !o_valid || i_ready;
  assign o_ready = adv;

  // Entry operation; gated to zero when idle so no X enters the pipe
  always_comb begin
    op = '0;
    if (i_valid) begin
      op.valid = 1'b1;
      op.tag   = i_tag;
      op.dvd   = i_dividend;
      op.dvs   = i_divisor;
      op.orig  = i_dividend;
      op.dz    = (i_divisor == '0);
`ifdef DIVIDER_SIGNED_EN
      if (i_signed) begin
        op.neg_r = i_dividend[WIDTH-1];
        op.neg_q = (i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1]) && !op.dz;
        if (i_dividend[WIDTH-1]) op.dvd = -i_dividend;
        if (i_divisor[WIDTH-1])  op.dvs = -i_divisor;
      end
`endif
    end
  end

`ifndef DIVIDER_SIGNED_EN
  logic unused_signed;
  assign unused_signed = i_signed;
`endif

  always_comb begin
    nxt[0] = step(op);
    for (int unsigned k = 1; k < STAGES; k++) begin
      nxt[k] = step(st[k-1]);
    end
  end

  // Whole pipe advances together; a stall holds every stage including bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st[k] <= nxt[k];
      end
    end
  end

  // Sign fix-up and divide-by-zero override on the last stage
  always_comb begin
    o_tag       = last.tag;
    o_quotient  = last.quo;
    o_remainder = last.rem;
`ifdef DIVIDER_SIGNED_EN
    if (last.neg_q) o_quotient  = -last.quo;
    if (last.neg_r) o_remainder = -last.rem;
`endif
    if (last.dz) begin
      o_quotient  = '1;
      o_remainder = last.orig;
    end
  end

endmodule

// File: tb/tb_divider_pipelined.sv
// Self-checking bench for divider_pipelined against an arithmetic reference model.
module tb_divider_pipelined;

  localparam int unsigned WIDTH  = 32;
  localparam int unsigned STAGES = 8;
  localparam int unsigned TAG_W  = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_dividend;
  logic [WIDTH-1:0] i_divisor;
  logic             i_signed;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_quotient;
  logic [WIDTH-1:0] o_remainder;
  logic [TAG_W-1:0] o_tag;

  int checks = 0;
  int passed = 0;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] r;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t expq[$];

  divider_pipelined #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_dividend(i_dividend), .i_divisor(i_divisor), .i_signed(i_signed),
    .i_tag(i_tag), .o_valid(o_valid), .i_ready(i_ready),
    .o_quotient(o_quotient), .o_remainder(o_remainder), .o_tag(o_tag)
  );

  always #5 clk = ~clk;

  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic sgn, output logic [WIDTH-1:0] q,
                                output logic [WIDTH-1:0] r);
    if (b == '0) begin
      q = '1;
      r = a;
    end
`ifdef DIVIDER_SIGNED_EN
    else if (sgn) begin
      longint sa;
      longint sb;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = WIDTH'(sa / sb);
      r  = WIDTH'(sa % sb);
    end
`endif
    else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_op(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b,
                         output logic sgn, output logic [TAG_W-1:0] tag);
    a = $urandom;
    case ($urandom_range(0, 4))
      0:       b = $urandom;
      1:       b = WIDTH'($urandom_range(1, 15));
      2:       b = '0;
      3:       b = a >> $urandom_range(0, 8);
      default: b = -WIDTH'($urandom_range(1, 9));
    endcase
    sgn = 1'($urandom_range(0, 1));
    tag = TAG_W'($urandom);
  endtask

  // Issues one op on an idle pipe and waits for its result (bounded)
  task automatic run_single(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic sgn, input logic [TAG_W-1:0] tag,
                            output int lat, output logic [WIDTH-1:0] q,
                            output logic [WIDTH-1:0] r, output logic [TAG_W-1:0] t);
    i_ready    = 1'b1;
    i_valid    = 1'b1;
    i_dividend = a;
    i_divisor  = b;
    i_signed   = sgn;
    i_tag      = tag;
    tick();
    lat     = 1;
    i_valid = 1'b0;
    while (!o_valid && lat < 30) begin
      tick();
      lat++;
    end
    q = o_quotient;
    r = o_remainder;
    t = o_tag;
    tick();
  endtask

  task automatic test_reset();
    int stale;
    rst        = 1'b1;
    i_ready    = 1'b1;
    i_valid    = 1'b1;
    i_dividend = 32'd5;
    i_divisor  = 32'd1;
    i_signed   = 1'b0;
    i_tag      = 5'd7;
    tick();
    tick();
    checks++; if (o_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", o_valid); else passed++;
    checks++; if (o_quotient !== '0) $display("FAIL reset_quotient: got %h expected 0", o_quotient); else passed++;
    checks++; if (o_remainder !== '0) $display("FAIL reset_remainder: got %h expected 0", o_remainder); else passed++;
    checks++; if (o_tag !== '0) $display("FAIL reset_tag: got %h expected 0", o_tag); else passed++;
    rst     = 1'b0;
    i_valid = 1'b0;
    #1;
    checks++; if (o_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", o_ready); else passed++;
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (o_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) $display("FAIL reset_no_accept: got %0d results expected 0", stale); else passed++;
  endtask

  task automatic test_basic();
    int lat;
    logic [WIDTH-1:0] q, r;
    logic [TAG_W-1:0] t;
    run_single(32'd100, 32'd7, 1'b0, 5'd3, lat, q, r, t);
    checks++; if (lat != STAGES) $display("FAIL basic_latency: got %0d expected %0d", lat, STAGES); else passed++;
    checks++; if (q !== 32'd14) $display("FAIL basic_quotient: got %0d expected 14", q); else passed++;
    checks++; if (r !== 32'd2) $display("FAIL basic_remainder: got %0d expected 2", r); else passed++;
    checks++; if (t !== 5'd3) $display("FAIL basic_tag: got %0d expected 3", t); else passed++;
  endtask

  task automatic test_div_zero();
    int lat;
    logic [WIDTH-1:0] q, r;
    logic [TAG_W-1:0] t;
    for (int s = 0; s < 2; s++) begin
      run_single(32'hDEADBEEF, 32'd0, 1'(s), 5'd9, lat, q, r, t);
      checks++; if (q !== 32'hFFFFFFFF) $display("FAIL divzero_quotient s=%0d: got %h expected ffffffff", s, q); else passed++;
      checks++; if (r !== 32'hDEADBEEF) $display("FAIL divzero_remainder s=%0d: got %h expected deadbeef", s, r); else passed++;
    end
  endtask

  task automatic test_signed();
    int lat;
    logic [WIDTH-1:0] q, r;
    logic [TAG_W-1:0] t;
    logic [WIDTH-1:0] eq1, er1, eq2, er2;
`ifdef DIVIDER_SIGNED_EN
    eq1 = 32'hFFFFFFFD; er1 = 32'hFFFFFFFF;
    eq2 = 32'h80000000; er2 = 32'h00000000;
`else
    eq1 = 32'h7FFFFFFC; er1 = 32'h00000001;
    eq2 = 32'h00000000; er2 = 32'h80000000;
`endif
    run_single(32'hFFFFFFF9, 32'd2, 1'b1, 5'd4, lat, q, r, t);
    checks++; if (q !== eq1) $display("FAIL signed_m7_2_quotient: got %h expected %h", q, eq1); else passed++;
    checks++; if (r !== er1) $display("FAIL signed_m7_2_remainder: got %h expected %h", r, er1); else passed++;
    run_single(32'h80000000, 32'hFFFFFFFF, 1'b1, 5'd5, lat, q, r, t);
    checks++; if (q !== eq2) $display("FAIL signed_ovf_quotient: got %h expected %h", q, eq2); else passed++;
    checks++; if (r !== er2) $display("FAIL signed_ovf_remainder: got %h expected %h", r, er2); else passed++;
  endtask

  task automatic test_back_to_back();
    int issued, got, first, last;
    logic [WIDTH-1:0] a, b, eq, er;
    logic sgn;
    logic [TAG_W-1:0] tag;
    exp_t e;
    issued = 0; got = 0; first = -1; last = -1;
    expq.delete();
    i_ready = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      #1;
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          checks++; $display("FAIL b2b_extra: got result %h expected none", o_quotient);
        end else begin
          e = expq.pop_front();
          checks++; if (o_quotient !== e.q) $display("FAIL b2b_quotient: got %h expected %h", o_quotient, e.q); else passed++;
          checks++; if (o_remainder !== e.r) $display("FAIL b2b_remainder: got %h expected %h", o_remainder, e.r); else passed++;
          checks++; if (o_tag !== e.tag) $display("FAIL b2b_tag: got %h expected %h", o_tag, e.tag); else passed++;
        end
        got++;
        if (first < 0) first = cyc;
        last = cyc;
      end
      if (issued < 20) begin
        rand_op(a, b, sgn, tag);
        i_valid = 1'b1; i_dividend = a; i_divisor = b; i_signed = sgn; i_tag = tag;
        if (o_ready) begin
          model(a, b, sgn, eq, er);
          expq.push_back('{q: eq, r: er, tag: tag});
          issued++;
        end
      end else begin
        i_valid = 1'b0;
      end
      tick();
    end
    checks++; if (got != 20) $display("FAIL b2b_count: got %0d expected 20", got); else passed++;
    checks++; if (last - first != 19) $display("FAIL b2b_spacing: got %0d expected 19", last - first); else passed++;
  endtask

  task automatic test_backpressure();
    int issued, got;
    logic [WIDTH-1:0] a, b, eq, er, sq, sr;
    logic sgn, have;
    logic [TAG_W-1:0] tag, stag;
    exp_t e;
    issued = 0; got = 0; have = 1'b0;
    sq = '0; sr = '0; stag = '0;
    a = '0; b = '0; sgn = 1'b0; tag = '0;
    expq.delete();
    for (int cyc = 0; cyc < 60; cyc++) begin
      i_ready = !(cyc >= 8 && cyc < 13);
      #1;
      if (cyc >= 8 && cyc < 13) begin
        checks++; if (o_ready !== 1'b0) $display("FAIL bp_ready cyc=%0d: got %b expected 0", cyc, o_ready); else passed++;
        if (cyc == 8) begin
          checks++; if (o_valid !== 1'b1) $display("FAIL bp_full: got %b expected 1", o_valid); else passed++;
          sq = o_quotient; sr = o_remainder; stag = o_tag;
        end else begin
          checks++;
          if (o_valid !== 1'b1 || o_quotient !== sq || o_remainder !== sr || o_tag !== stag)
            $display("FAIL bp_stable cyc=%0d: got %b/%h/%h/%h expected 1/%h/%h/%h",
                     cyc, o_valid, o_quotient, o_remainder, o_tag, sq, sr, stag);
          else passed++;
        end
      end
      if (o_valid && i_ready) begin
        if (expq.size() == 0) begin
          checks++; $display("FAIL bp_extra: got result %h expected none", o_quotient);
        end else begin
          e = expq.pop_front();
          checks++;
          if (o_quotient !== e.q || o_remainder !== e.r || o_tag !== e.tag)
            $display("FAIL bp_result: got %h/%h/%h expected %h/%h/%h",
                     o_quotient, o_remainder, o_tag, e.q, e.r, e.tag);
          else passed++;
        end
        got++;
      end
      if (issued < 12) begin
        if (!have) begin
          rand_op(a, b, sgn, tag);
          have = 1'b1;
        end
        i_valid = 1'b1; i_dividend = a; i_divisor = b; i_signed = sgn; i_tag = tag;
        if (o_ready) begin
          model(a, b, sgn, eq, er);
          expq.push_back('{q: eq, r: er, tag: tag});
          issued++;
          have = 1'b0;
        end
      end else begin
        i_valid = 1'b0;
      end
      tick();
    end
    i_ready = 1'b1;
    checks++; if (got != 12) $display("FAIL bp_count: got %0d expected 12", got); else passed++;
    checks++; if (expq.size() != 0) $display("FAIL bp_lost: got %0d pending expected 0", expq.size()); else passed++;
  endtask

  task automatic test_reset_midflight();
    int stale, lat;
    logic [WIDTH-1:0] q, r;
    logic [TAG_W-1:0] t;
    i_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      i_valid = 1'b1; i_dividend = $urandom; i_divisor = WIDTH'($urandom_range(1, 99));
      i_signed = 1'b0; i_tag = TAG_W'(i + 1);
      tick();
    end
    i_valid = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (o_valid !== 1'b0) $display("FAIL mid_reset_valid: got %b expected 0", o_valid); else passed++;
    checks++;
    if (o_quotient !== '0 || o_remainder !== '0 || o_tag !== '0)
      $display("FAIL mid_reset_outputs: got %h/%h/%h expected 0/0/0", o_quotient, o_remainder, o_tag);
    else passed++;
    stale = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (o_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) $display("FAIL mid_reset_stale: got %0d results expected 0", stale); else passed++;
    run_single(32'd9, 32'd3, 1'b0, 5'd11, lat, q, r, t);
    checks++; if (lat != STAGES) $display("FAIL fresh_latency: got %0d expected %0d", lat, STAGES); else passed++;
    checks++; if (q !== 32'd3) $display("FAIL fresh_quotient: got %0d expected 3", q); else passed++;
    checks++; if (r !== 32'd0) $display("FAIL fresh_remainder: got %0d expected 0", r); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_signed();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
